// File: rtl/router_fsm_np.sv
// Router ingress controller: decodes the header to a one-hot port and sequences
// header/payload/parity writes. Handles back-pressure, soft resets, bad-address drops and wait timeouts.
module router_fsm_np #(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 32,
    parameter int TMO_W        = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 fifo_full,
    input  logic                 low_pkt_valid,
    input  logic                 parity_done,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] dest_sel,
    output logic                 drop_pkt,
    output logic                 timeout_err
);
    typedef enum logic [3:0] {
        DECODE          = 4'd0,
        WAIT_EMPTY      = 4'd1,
        LOAD_FIRST      = 4'd2,
        LOAD_DATA       = 4'd3,
        FIFO_FULL       = 4'd4,
        LOAD_AFTER_FULL = 4'd5,
        LOAD_PARITY     = 4'd6,
        CHECK_PARITY    = 4'd7,
        DROP            = 4'd8
    } state_t;

    localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(WAIT_TIMEOUT - 1);

    state_t               state, state_nxt;
    logic [NUM_PORTS-1:0] addr_oh, dest_nxt;
    logic [TMO_W-1:0]     cnt, cnt_nxt;
    logic                 addr_ok, soft_hit, tmo_nxt;

    // Out-of-range addresses decode to all-zero, which doubles as the drop condition.
    always_comb begin
        addr_oh = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            addr_oh[i] = (data_in == ADDR_W'(i));
    end

    assign addr_ok  = |addr_oh;
    assign soft_hit = |(soft_reset & dest_sel);

    always_comb begin
        state_nxt = state;
        dest_nxt  = dest_sel;
        cnt_nxt   = cnt;
        tmo_nxt   = 1'b0;
        if (state == DECODE && pkt_valid)
            dest_nxt = addr_oh;
        if (soft_hit) begin
            state_nxt = DECODE;
            dest_nxt  = '0;
        end else begin
            case (state)
                DECODE: begin
                    if (pkt_valid) begin
                        if (!addr_ok)
                            state_nxt = DROP;
                        else if (|(fifo_empty & addr_oh))
                            state_nxt = LOAD_FIRST;
                        else begin
                            state_nxt = WAIT_EMPTY;
                            cnt_nxt   = '0;
                        end
                    end
                end
                WAIT_EMPTY: begin
                    if (|(fifo_empty & dest_sel))
                        state_nxt = LOAD_FIRST;
                    else if (cnt == CNT_LAST) begin
                        state_nxt = DROP;
                        tmo_nxt   = 1'b1;
                    end else
                        cnt_nxt = cnt + 1'b1;
                end
                LOAD_FIRST: state_nxt = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)
                        state_nxt = FIFO_FULL;
                    else if (!pkt_valid)
                        state_nxt = LOAD_PARITY;
                end
                FIFO_FULL: begin
                    if (!fifo_full)
                        state_nxt = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)
                        state_nxt = DECODE;
                    else if (low_pkt_valid)
                        state_nxt = LOAD_PARITY;
                    else
                        state_nxt = LOAD_DATA;
                end
                LOAD_PARITY:  state_nxt = CHECK_PARITY;
                CHECK_PARITY: state_nxt = fifo_full ? FIFO_FULL : DECODE;
                DROP: begin
                    if (!pkt_valid)
                        state_nxt = DECODE;
                end
                default: state_nxt = DECODE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= DECODE;
            dest_sel    <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            dest_sel    <= dest_nxt;
            cnt         <= cnt_nxt;
            timeout_err <= tmo_nxt;
        end
    end

    assign detect_add    = (state == DECODE);
    assign lfd_state     = (state == LOAD_FIRST);
    assign ld_state      = (state == LOAD_DATA);
    assign full_state    = (state == FIFO_FULL);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign rst_int_reg   = (state == CHECK_PARITY);
    assign drop_pkt      = (state == DROP);
    assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                           (state == LOAD_AFTER_FULL);
    // DROP leaves busy low so the source drains the discarded bytes.
    assign busy          = (state == LOAD_FIRST) || (state == WAIT_EMPTY) ||
                           (state == FIFO_FULL) || (state == LOAD_AFTER_FULL) ||
                           (state == LOAD_PARITY) || (state == CHECK_PARITY);
endmodule

// File: tb/tb_router_fsm_np.sv
// Randomized bench for router_fsm_np against a packet-phase reference model,
// plus short directed runs for the nominal packet and the wait timeout.
module tb_router_fsm_np;
    localparam int NP = 3;
    localparam int AW = 2;
    localparam int WT = 32;
    localparam int TW = 6;

    localparam int P_IDLE = 0, P_WAIT = 1, P_LF = 2, P_LD = 3, P_FULL = 4,
                   P_LAF = 5, P_LP = 6, P_CP = 7, P_DROP = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          pkt_valid;
    logic [AW-1:0] data_in;
    logic [NP-1:0] fifo_empty, soft_reset;
    logic          fifo_full, low_pkt_valid, parity_done;
    logic          detect_add, lfd_state, ld_state, laf_state, full_state;
    logic          rst_int_reg, write_enb_reg, busy, drop_pkt, timeout_err;
    logic [NP-1:0] dest_sel;

    router_fsm_np #(.NUM_PORTS(NP), .ADDR_W(AW), .WAIT_TIMEOUT(WT), .TMO_W(TW)) dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_empty(fifo_empty), .soft_reset(soft_reset), .fifo_full(fifo_full),
        .low_pkt_valid(low_pkt_valid), .parity_done(parity_done),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy), .dest_sel(dest_sel),
        .drop_pkt(drop_pkt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int we_seen, tmo_seen, tmo_model;

    // Reference: packet phase, selected port (-1 = none), wait count, timeout flag.
    int ph   = P_IDLE;
    int msel = -1;
    int mcnt = 0;
    bit mtmo = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [8:0] exp_outs(input int p);
        logic we, bz;
        we = (p == P_LD) || (p == P_LP) || (p == P_LAF);
        bz = (p == P_LF) || (p == P_WAIT) || (p == P_FULL) || (p == P_LAF) ||
             (p == P_LP) || (p == P_CP);
        return {p == P_IDLE, p == P_LF, p == P_LD, p == P_LAF, p == P_FULL,
                p == P_CP, p == P_DROP, we, bz};
    endfunction

    task automatic model_step(input logic r, input logic pv, input logic [AW-1:0] din,
                              input logic [NP-1:0] fe, input logic [NP-1:0] sr,
                              input logic ff, input logic lpv, input logic pd);
        int nph, nsel, ncnt;
        bit ntmo, hit;
        if (!r) begin
            ph = P_IDLE; msel = -1; mcnt = 0; mtmo = 1'b0;
            return;
        end
        nph = ph; nsel = msel; ncnt = mcnt; ntmo = 1'b0;
        hit = 1'b0;
        if (msel >= 0) hit = sr[msel[1:0]];
        if (hit) begin
            nph = P_IDLE; nsel = -1;
        end else begin
            case (ph)
                P_IDLE: if (pv) begin
                    if (int'(din) >= NP) begin nph = P_DROP; nsel = -1; end
                    else begin
                        nsel = int'(din);
                        if (fe[din]) nph = P_LF;
                        else begin nph = P_WAIT; ncnt = 0; end
                    end
                end
                P_WAIT: begin
                    if (fe[msel[1:0]]) nph = P_LF;
                    else if (mcnt == WT - 1) begin nph = P_DROP; ntmo = 1'b1; end
                    else ncnt = mcnt + 1;
                end
                P_LF:   nph = P_LD;
                P_LD:   if (ff) nph = P_FULL; else if (!pv) nph = P_LP;
                P_FULL: if (!ff) nph = P_LAF;
                P_LAF:  nph = pd ? P_IDLE : (lpv ? P_LP : P_LD);
                P_LP:   nph = P_CP;
                P_CP:   nph = ff ? P_FULL : P_IDLE;
                P_DROP: if (!pv) nph = P_IDLE;
                default: nph = P_IDLE;
            endcase
        end
        ph = nph; msel = nsel; mcnt = ncnt; mtmo = ntmo;
        if (ntmo) tmo_model++;
    endtask

    task automatic cyc(input logic r, input logic pv, input logic [AW-1:0] din,
                       input logic [NP-1:0] fe, input logic [NP-1:0] sr,
                       input logic ff, input logic lpv, input logic pd);
        logic [8:0] got;
        @(negedge clk);
        rst = r; pkt_valid = pv; data_in = din; fifo_empty = fe; soft_reset = sr;
        fifo_full = ff; low_pkt_valid = lpv; parity_done = pd;
        model_step(r, pv, din, fe, sr, ff, lpv, pd);
        @(posedge clk);
        #1;
        got = {detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, drop_pkt, write_enb_reg, busy};
        chk("outs", 32'(got), 32'(exp_outs(ph)));
        chk("dest_sel", 32'(dest_sel), (msel < 0) ? 32'd0 : (32'd1 << msel));
        chk("timeout_err", 32'(timeout_err), 32'(mtmo));
        if (write_enb_reg === 1'b1) we_seen++;
        if (timeout_err === 1'b1) tmo_seen++;
    endtask

    task automatic rnd_cyc(input int mode);
        logic          r, pv, ff, lpv, pd;
        logic [AW-1:0] din;
        logic [NP-1:0] fe, sr;
        r   = !(mode == 3 && $urandom_range(0, 49) == 0);
        pv  = ($urandom_range(0, 99) < 85);
        din = AW'($urandom_range(0, 3));
        for (int i = 0; i < NP; i++) begin
            fe[i] = (mode == 1) ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 1) == 1);
            sr[i] = (mode == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
        end
        ff  = ($urandom_range(0, 99) < ((mode == 4) ? 50 : 20));
        lpv = ($urandom_range(0, 1) == 1);
        pd  = ($urandom_range(0, 9) < 3);
        cyc(r, pv, din, fe, sr, ff, lpv, pd);
    endtask

    initial begin
        rst = 1'b0; pkt_valid = 1'b0; data_in = '0; fifo_empty = '0; soft_reset = '0;
        fifo_full = 1'b0; low_pkt_valid = 1'b0; parity_done = 1'b0;
        tmo_model = 0;
        cyc(0, 1, 2'd1, 3'b000, 3'b000, 0, 0, 0);
        cyc(0, 0, 2'd0, 3'b000, 3'b000, 0, 0, 0);

        // Nominal packet to empty port 2: header, 4 payload cycles, parity.
        we_seen = 0;
        cyc(1, 1, 2'd2, 3'b100, 3'b000, 0, 0, 0);
        cyc(1, 1, 2'd0, 3'b100, 3'b000, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 2'd0, 3'b100, 3'b000, 0, 0, 0);
        cyc(1, 0, 2'd0, 3'b100, 3'b000, 0, 0, 0);
        cyc(1, 0, 2'd0, 3'b100, 3'b000, 0, 0, 0);
        cyc(1, 0, 2'd0, 3'b100, 3'b000, 0, 0, 0);
        chk("nominal_we_cycles", 32'(we_seen), 32'd5);

        // Port 0 never empties: exactly one timeout pulse, no writes.
        we_seen = 0; tmo_seen = 0;
        cyc(1, 1, 2'd0, 3'b000, 3'b000, 0, 0, 0);
        for (int i = 0; i < WT + 4; i++) cyc(1, 1, 2'd1, 3'b000, 3'b000, 0, 0, 0);
        cyc(1, 0, 2'd0, 3'b000, 3'b000, 0, 0, 0);
        chk("timeout_pulses", 32'(tmo_seen), 32'd1);
        chk("timeout_we_cycles", 32'(we_seen), 32'd0);

        tmo_seen = 0; tmo_model = 0;
        for (int seg = 0; seg < 20; seg++)
            for (int c = 0; c < 400; c++) rnd_cyc(seg % 5);
        chk("rand_timeout_total", 32'(tmo_seen), 32'(tmo_model));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
